// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : FSM state codes (free, divide-by-zero, iterating, result held)
//   DIV_RESULT_* : levels of ready_o
//   DIV_START/STOP : levels of start_i
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring step (combinational).
//   i_partial_rem : running remainder, always < i_divisor
//   i_next_bit    : next dividend bit shifted in (MSB first)
//   i_divisor     : magnitude of divisor
//   o_new_rem     : updated remainder
//   o_q_bit       : quotient bit produced by this step
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_partial_rem,
  input  logic              i_next_bit,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_new_rem,
  output logic              o_q_bit
);

  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_diff;

  assign w_trial = {i_partial_rem, i_next_bit};
  assign o_q_bit = (w_trial >= {1'b0, i_divisor});
  // Only used when trial >= divisor; then the difference is below the
  // divisor and fits in DATA_W bits, so the trial's top bit can be dropped.
  assign w_diff    = w_trial[DATA_W-1:0] - i_divisor;
  assign o_new_rem = o_q_bit ? w_diff : w_trial[DATA_W-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Holds the pipeline via stallreq_o while a divide is in flight.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : divide requested (held until ready_o is seen)
//   signed_i     : 1 = signed divide
//   opdata1_i/2_i: dividend / divisor, sampled only in DIV_FREE
//   annul_i      : abort from any state
//   result_o     : {remainder, quotient}, valid while ready_o
//   ready_o      : registered result-valid
//   stallreq_o   : start_i & ~ready_o & ~annul_i
//
// state      | meaning
// DIV_FREE   | idle, waiting for start_i
// DIV_BYZERO | divisor was zero, result forced to 0
// DIV_ON     | DATA_W iteration cycles
// DIV_END    | result held; ready_o raised, waits for start_i to fall
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  div_state_e            r_state;
  div_state_e            w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_divisor;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic [DATA_W-1:0]     w_abs1;
  logic [DATA_W-1:0]     w_abs2;
  logic [DATA_W-1:0]     w_new_rem;
  logic                  w_q_bit;
  logic [DATA_W-1:0]     w_quo_next;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;
  logic                  w_last;
  logic                  w_go;

  assign w_go   = (start_i == DIV_START) && !annul_i;
  assign w_abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  // The counter runs 0..DATA_W; the step taken at DATA_W-1 is the final one
  // and its outcome goes straight into the result register.
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  // r_quo holds the unconsumed dividend bits in its upper part and collects
  // quotient bits from the bottom, so one register serves both.
  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .i_partial_rem (r_rem),
    .i_next_bit    (r_quo[DATA_W-1]),
    .i_divisor     (r_divisor),
    .o_new_rem     (w_new_rem),
    .o_q_bit       (w_q_bit)
  );

  assign w_quo_next = {r_quo[DATA_W-2:0], w_q_bit};
  assign w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem_fix  = r_neg_r ? -w_new_rem  : w_new_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (annul_i) begin
      w_next_state = DIV_FREE;
    end else begin
      case (r_state)
        DIV_FREE:   if (w_go) w_next_state = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        DIV_BYZERO: w_next_state = DIV_END;
        DIV_ON:     if (w_last) w_next_state = DIV_END;
        DIV_END:    if (start_i == DIV_STOP) w_next_state = DIV_FREE;
        default:    w_next_state = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else if (annul_i) begin
      r_ready <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready <= DIV_RESULT_NOT_READY;
          if (w_go) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_abs1;
            r_divisor <= w_abs2;
            r_neg_q   <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg_r   <= signed_i && opdata1_i[DATA_W-1];
          end
        end
        DIV_BYZERO: r_result <= '0;
        DIV_ON: begin
          r_rem <= w_new_rem;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_result <= {w_rem_fix, w_quo_fix};
        end
        DIV_END: begin
          r_ready <= (start_i == DIV_STOP) ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
        end
        default: r_ready <= DIV_RESULT_NOT_READY;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready & ~annul_i;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'h0;
  logic        ready_d = 1'b0;

  always #5 clk = ~clk;

  div_iter #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend sign, which is the architectural rule.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (ready_o && !ready_d) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got result %h with no divide outstanding", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
    ready_d = ready_o;
  end

  // Issue one divide and follow its handshake. With pre_annul, the first
  // cycle also carries annul_i, which must prevent that cycle from starting it.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit pre_annul);
    int lat;
    bit done;
    logic [63:0] e;
    e = ref_div(sgn, a, b);
    @(negedge clk);
    exp_q.push_back(e);
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    if (pre_annul) begin
      annul_i = 1'b1;
      #1 check("stall_annul", {63'h0, stallreq_o}, 64'h0);
      @(negedge clk);
      annul_i = 1'b0;
    end
    #1 check("stall_start", {63'h0, stallreq_o}, 64'h1);
    lat  = 0;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
      end
      if (ready_o) done = 1'b1;
      else if (stallreq_o !== 1'b1) check("stall_busy", {63'h0, stallreq_o}, 64'h1);
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: ready_o not seen within 80 cycles for %h / %h", a, b);
      void'(exp_q.pop_front());
    end else begin
      check("latency", 64'(lat), (b == 32'h0) ? 64'd3 : 64'd34);
      check("stall_done", {63'h0, stallreq_o}, 64'h0);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1 check("ready_drop", {63'h0, ready_o}, 64'h0);
    check("result_held", result_o, e);
    last_res = e;
  endtask

  initial begin
    logic [31:0] a, b;
    bit sgn;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    #12;
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    check("reset_stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", last_res, {32'd2, 32'd14});
    run_div(1'b1, -32'sd7, 32'd2, 1'b0);
    run_div(1'b1, 32'd7, -32'sd2, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1'b0);
    run_div(1'b1, 32'hFFFFFFF0, 32'd0, 1'b0);
    run_div(1'b0, 32'd77, 32'd10, 1'b1);

    // Annul at iteration 10: no result, result_o unchanged.
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1 check("stall_annul_on", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("annul_no_ready", {63'h0, ready_o}, 64'h0);
    check("annul_result_kept", result_o, last_res);
    run_div(1'b0, 32'd9, 32'd3, 1'b0);
    check("divu_9_3", last_res, {32'd0, 32'd3});

    // Asynchronous reset between edges in the middle of an iteration run.
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_ready", {63'h0, ready_o}, 64'h0);
    check("rst_result", result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    run_div(1'b1, 32'd50, -32'sd9, 1'b0);

    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d results never seen", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
